// File: rtl/register_bank.sv
// Per-lane SIMT register file: 16 lanes x 64 entries x 64 bits, one shared-address write port
// and two independent shared-address combinational read ports with per-lane enables.
module register_bank #(
   parameter int unsigned LANES = 16,
   parameter int unsigned NREGS = 64,
   parameter int unsigned AW    = 6,
   parameter int unsigned DW    = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [15:0]   read_en_0,
   input  logic [15:0]   read_en_1,
   input  logic [AW-1:0] raddr_0,
   input  logic [AW-1:0] raddr_1,
   input  logic [15:0]   write_en,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata_0,
   input  logic [DW-1:0] wdata_1,
   input  logic [DW-1:0] wdata_2,
   input  logic [DW-1:0] wdata_3,
   input  logic [DW-1:0] wdata_4,
   input  logic [DW-1:0] wdata_5,
   input  logic [DW-1:0] wdata_6,
   input  logic [DW-1:0] wdata_7,
   input  logic [DW-1:0] wdata_8,
   input  logic [DW-1:0] wdata_9,
   input  logic [DW-1:0] wdata_10,
   input  logic [DW-1:0] wdata_11,
   input  logic [DW-1:0] wdata_12,
   input  logic [DW-1:0] wdata_13,
   input  logic [DW-1:0] wdata_14,
   input  logic [DW-1:0] wdata_15,
   output logic [DW-1:0] rdata_0_0,
   output logic [DW-1:0] rdata_0_1,
   output logic [DW-1:0] rdata_0_2,
   output logic [DW-1:0] rdata_0_3,
   output logic [DW-1:0] rdata_0_4,
   output logic [DW-1:0] rdata_0_5,
   output logic [DW-1:0] rdata_0_6,
   output logic [DW-1:0] rdata_0_7,
   output logic [DW-1:0] rdata_0_8,
   output logic [DW-1:0] rdata_0_9,
   output logic [DW-1:0] rdata_0_10,
   output logic [DW-1:0] rdata_0_11,
   output logic [DW-1:0] rdata_0_12,
   output logic [DW-1:0] rdata_0_13,
   output logic [DW-1:0] rdata_0_14,
   output logic [DW-1:0] rdata_0_15,
   output logic [DW-1:0] rdata_1_0,
   output logic [DW-1:0] rdata_1_1,
   output logic [DW-1:0] rdata_1_2,
   output logic [DW-1:0] rdata_1_3,
   output logic [DW-1:0] rdata_1_4,
   output logic [DW-1:0] rdata_1_5,
   output logic [DW-1:0] rdata_1_6,
   output logic [DW-1:0] rdata_1_7,
   output logic [DW-1:0] rdata_1_8,
   output logic [DW-1:0] rdata_1_9,
   output logic [DW-1:0] rdata_1_10,
   output logic [DW-1:0] rdata_1_11,
   output logic [DW-1:0] rdata_1_12,
   output logic [DW-1:0] rdata_1_13,
   output logic [DW-1:0] rdata_1_14,
   output logic [DW-1:0] rdata_1_15
);

   logic [DW-1:0] mem [LANES][NREGS];
   logic [DW-1:0] wdata [LANES];
   logic [DW-1:0] rd0   [LANES];
   logic [DW-1:0] rd1   [LANES];

   assign wdata[0]  = wdata_0;
   assign wdata[1]  = wdata_1;
   assign wdata[2]  = wdata_2;
   assign wdata[3]  = wdata_3;
   assign wdata[4]  = wdata_4;
   assign wdata[5]  = wdata_5;
   assign wdata[6]  = wdata_6;
   assign wdata[7]  = wdata_7;
   assign wdata[8]  = wdata_8;
   assign wdata[9]  = wdata_9;
   assign wdata[10] = wdata_10;
   assign wdata[11] = wdata_11;
   assign wdata[12] = wdata_12;
   assign wdata[13] = wdata_13;
   assign wdata[14] = wdata_14;
   assign wdata[15] = wdata_15;

   // Reset has priority: a write presented in a reset cycle is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int l = 0; l < LANES; l++) begin
            for (int r = 0; r < NREGS; r++) begin
               mem[l][r] <= '0;
            end
         end
      end else begin
         for (int l = 0; l < LANES; l++) begin
            if (write_en[l]) begin
               mem[l][waddr] <= wdata[l];
            end
         end
      end
   end

   // No write-to-read bypass: reads always see the pre-edge contents.
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         rd0[l] = '0;
         rd1[l] = '0;
         if (read_en_0[l]) rd0[l] = mem[l][raddr_0];
         if (read_en_1[l]) rd1[l] = mem[l][raddr_1];
      end
   end

   assign rdata_0_0  = rd0[0];
   assign rdata_0_1  = rd0[1];
   assign rdata_0_2  = rd0[2];
   assign rdata_0_3  = rd0[3];
   assign rdata_0_4  = rd0[4];
   assign rdata_0_5  = rd0[5];
   assign rdata_0_6  = rd0[6];
   assign rdata_0_7  = rd0[7];
   assign rdata_0_8  = rd0[8];
   assign rdata_0_9  = rd0[9];
   assign rdata_0_10 = rd0[10];
   assign rdata_0_11 = rd0[11];
   assign rdata_0_12 = rd0[12];
   assign rdata_0_13 = rd0[13];
   assign rdata_0_14 = rd0[14];
   assign rdata_0_15 = rd0[15];

   assign rdata_1_0  = rd1[0];
   assign rdata_1_1  = rd1[1];
   assign rdata_1_2  = rd1[2];
   assign rdata_1_3  = rd1[3];
   assign rdata_1_4  = rd1[4];
   assign rdata_1_5  = rd1[5];
   assign rdata_1_6  = rd1[6];
   assign rdata_1_7  = rd1[7];
   assign rdata_1_8  = rd1[8];
   assign rdata_1_9  = rd1[9];
   assign rdata_1_10 = rd1[10];
   assign rdata_1_11 = rd1[11];
   assign rdata_1_12 = rd1[12];
   assign rdata_1_13 = rd1[13];
   assign rdata_1_14 = rd1[14];
   assign rdata_1_15 = rd1[15];

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank: directed writes/reads against a bench-side copy of the
// register contents, covering reset, enable gating, dual ports, collisions and reset priority.
module tb_register_bank;

   logic        clk;
   logic        rst;
   logic [15:0] read_en_0;
   logic [15:0] read_en_1;
   logic [5:0]  raddr_0;
   logic [5:0]  raddr_1;
   logic [15:0] write_en;
   logic [5:0]  waddr;
   logic [63:0] wdata [16];
   logic [63:0] rdata0 [16];
   logic [63:0] rdata1 [16];

   logic [63:0] model [16][64];
   int          n_cmp;
   int          n_bad;

   register_bank dut (
      .clk        (clk),
      .rst        (rst),
      .read_en_0  (read_en_0),
      .read_en_1  (read_en_1),
      .raddr_0    (raddr_0),
      .raddr_1    (raddr_1),
      .write_en   (write_en),
      .waddr      (waddr),
      .wdata_0    (wdata[0]),
      .wdata_1    (wdata[1]),
      .wdata_2    (wdata[2]),
      .wdata_3    (wdata[3]),
      .wdata_4    (wdata[4]),
      .wdata_5    (wdata[5]),
      .wdata_6    (wdata[6]),
      .wdata_7    (wdata[7]),
      .wdata_8    (wdata[8]),
      .wdata_9    (wdata[9]),
      .wdata_10   (wdata[10]),
      .wdata_11   (wdata[11]),
      .wdata_12   (wdata[12]),
      .wdata_13   (wdata[13]),
      .wdata_14   (wdata[14]),
      .wdata_15   (wdata[15]),
      .rdata_0_0  (rdata0[0]),
      .rdata_0_1  (rdata0[1]),
      .rdata_0_2  (rdata0[2]),
      .rdata_0_3  (rdata0[3]),
      .rdata_0_4  (rdata0[4]),
      .rdata_0_5  (rdata0[5]),
      .rdata_0_6  (rdata0[6]),
      .rdata_0_7  (rdata0[7]),
      .rdata_0_8  (rdata0[8]),
      .rdata_0_9  (rdata0[9]),
      .rdata_0_10 (rdata0[10]),
      .rdata_0_11 (rdata0[11]),
      .rdata_0_12 (rdata0[12]),
      .rdata_0_13 (rdata0[13]),
      .rdata_0_14 (rdata0[14]),
      .rdata_0_15 (rdata0[15]),
      .rdata_1_0  (rdata1[0]),
      .rdata_1_1  (rdata1[1]),
      .rdata_1_2  (rdata1[2]),
      .rdata_1_3  (rdata1[3]),
      .rdata_1_4  (rdata1[4]),
      .rdata_1_5  (rdata1[5]),
      .rdata_1_6  (rdata1[6]),
      .rdata_1_7  (rdata1[7]),
      .rdata_1_8  (rdata1[8]),
      .rdata_1_9  (rdata1[9]),
      .rdata_1_10 (rdata1[10]),
      .rdata_1_11 (rdata1[11]),
      .rdata_1_12 (rdata1[12]),
      .rdata_1_13 (rdata1[13]),
      .rdata_1_14 (rdata1[14]),
      .rdata_1_15 (rdata1[15])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic clear_model();
      for (int l = 0; l < 16; l++)
         for (int r = 0; r < 64; r++)
            model[l][r] = 64'h0;
   endtask

   task automatic rand_wdata();
      for (int l = 0; l < 16; l++) wdata[l] = {$urandom, $urandom};
   endtask

   // Drive a write for one edge; caller has already loaded wdata.
   task automatic do_write(input logic [15:0] mask, input logic [5:0] addr);
      @(posedge clk);
      #1;
      write_en = mask;
      waddr    = addr;
      @(posedge clk);
      #1;
      write_en = 16'h0;
      for (int l = 0; l < 16; l++)
         if (mask[l]) model[l][addr] = wdata[l];
   endtask

   task automatic check_read(input string tag, input logic [15:0] en0, input logic [15:0] en1,
                             input logic [5:0] a0, input logic [5:0] a1);
      read_en_0 = en0;
      read_en_1 = en1;
      raddr_0   = a0;
      raddr_1   = a1;
      #2;
      for (int l = 0; l < 16; l++) begin
         check_eq($sformatf("%s p0 l%0d a%0d", tag, l, a0), rdata0[l],
                  en0[l] ? model[l][a0] : 64'h0);
         check_eq($sformatf("%s p1 l%0d a%0d", tag, l, a1), rdata1[l],
                  en1[l] ? model[l][a1] : 64'h0);
      end
   endtask

   initial begin
      n_cmp     = 0;
      n_bad     = 0;
      rst       = 1'b1;
      read_en_0 = 16'h0;
      read_en_1 = 16'h0;
      raddr_0   = 6'd0;
      raddr_1   = 6'd0;
      write_en  = 16'h0;
      waddr     = 6'd0;
      for (int l = 0; l < 16; l++) wdata[l] = 64'h0;
      clear_model();

      @(posedge clk);
      #1;
      rst = 1'b0;

      // Outputs idle at zero with enables low, then every entry reads zero after reset.
      check_read("idle", 16'h0, 16'h0, 6'd0, 6'd0);
      for (int a = 0; a < 64; a++) check_read("rst_clr", 16'hFFFF, 16'hFFFF, a[5:0], a[5:0]);

      // All-lane writes, several rounds of fresh data per register.
      for (int rnd = 0; rnd < 3; rnd++) begin
         for (int a = 0; a < 32; a++) begin
            rand_wdata();
            do_write(16'hFFFF, a[5:0]);
            check_read("wr_p0", 16'hFFFF, 16'h0, a[5:0], 6'd0);
            check_read("wr_p1", 16'h0, 16'hFFFF, 6'd0, a[5:0]);
            check_read("wr_both", 16'hFFFF, 16'hFFFF, a[5:0], a[5:0]);
         end
      end

      // Single-lane write leaves other lanes untouched.
      rand_wdata();
      wdata[3] = 64'hDEADBEEF_CAFEF00D;
      do_write(16'h0008, 6'd5);
      check_read("lane3", 16'hFFFF, 16'h0, 6'd5, 6'd0);
      check_eq("lane3_pattern", rdata0[3], 64'hDEADBEEF_CAFEF00D);
      check_read("gated", 16'h0000, 16'h0, 6'd5, 6'd0);
      check_read("mixed_en", 16'hA5A5, 16'h5A5A, 6'd5, 6'd5);

      // Distinct data at 10 and 20, read simultaneously on different ports.
      rand_wdata();
      do_write(16'hFFFF, 6'd10);
      rand_wdata();
      do_write(16'hFFFF, 6'd20);
      check_read("indep", 16'hFFFF, 16'hFFFF, 6'd10, 6'd20);
      check_read("indep_swap", 16'hFFFF, 16'hFFFF, 6'd20, 6'd10);

      // Collision: old data before the edge, new data after; no bypass.
      @(posedge clk);
      #1;
      rand_wdata();
      write_en = 16'hFFFF;
      waddr    = 6'd7;
      check_read("coll_old", 16'hFFFF, 16'h0, 6'd7, 6'd0);
      @(posedge clk);
      #1;
      write_en = 16'h0;
      for (int l = 0; l < 16; l++) model[l][7] = wdata[l];
      check_read("coll_new", 16'hFFFF, 16'h0, 6'd7, 6'd0);

      // Fill everything, then reset with a concurrent write that must be discarded.
      for (int a = 0; a < 64; a++) begin
         rand_wdata();
         do_write(16'hFFFF, a[5:0]);
      end
      check_read("filled", 16'hFFFF, 16'hFFFF, 6'd63, 6'd3);
      @(posedge clk);
      #1;
      rand_wdata();
      rst      = 1'b1;
      write_en = 16'hFFFF;
      waddr    = 6'd3;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      write_en = 16'h0;
      clear_model();
      for (int a = 0; a < 64; a++) check_read("mid_rst", 16'hFFFF, 16'hFFFF, a[5:0], a[5:0]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
